// File: rtl/tb_sb_pkg.sv
// Shared types and helpers for the multi-channel in-order bench scoreboard.
package tb_sb_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISMATCH,
    ERR_UNEXPECTED,
    ERR_TIMEOUT
  } sb_err_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sb_chan_fifo.sv
// Single-clock expected-value queue for one scoreboard channel.
module sb_chan_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         tb_clk,
  input  logic         tb_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge tb_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/tb_scoreboard.sv
// In-order multi-channel scoreboard: masked compare against per-channel expected queues,
// saturating pass/error counters, stall watchdog and end-of-test sequencing.
module tb_scoreboard
  import tb_sb_pkg::*;
#(
  parameter int W       = 32,
  parameter int NCH     = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000,
  parameter int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             tb_clk,
  input  logic             tb_rst,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [CW-1:0]    exp_chan,
  input  logic [W-1:0]     exp_data,
  input  logic             act_valid,
  input  logic [CW-1:0]    act_chan,
  input  logic [W-1:0]     act_data,
  input  logic [W-1:0]     cmp_mask,
  input  logic             eot,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [1:0]       err_kind,
  output logic             timeout,
  output logic             done
);

  localparam int WDW = $clog2(TIMEOUT) + 1;

  logic [NCH-1:0]   w_push;
  logic [NCH-1:0]   w_pop;
  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_empty;
  logic [W-1:0]     w_head [NCH];
  logic             w_exp_ready;
  logic             w_act_hit;
  logic [W-1:0]     w_act_head;
  logic             w_match;
  logic             w_all_empty;
  logic             w_wd_fire;
  sb_state_e        w_state_nxt;

  sb_state_e        r_state;
  logic             r_res_pass;
  logic             r_res_mis;
  logic             r_res_unexp;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_flag;
  sb_err_e          r_err_kind;
  logic             r_timeout;
  logic [WDW-1:0]   r_wd;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    sb_chan_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .tb_clk  (tb_clk),
      .tb_rst  (tb_rst),
      .i_push  (w_push[g]),
      .i_data  (exp_data),
      .i_pop   (w_pop[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[g])
    );
  end

  // Out-of-range channel indices match no loop iteration, so they read as not-ready / unexpected.
  // NOTE: every signal driven here gets a default before the loop so no latch is inferred.
  always_comb begin
    w_exp_ready = 1'b0;
    w_act_hit   = 1'b0;
    w_act_head  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (exp_chan == CW'(i)) w_exp_ready = !w_full[i] && (r_state != DONE);
      if (act_chan == CW'(i) && !w_empty[i]) begin
        w_act_hit  = act_valid;
        w_act_head = w_head[i];
      end
    end
  end

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_push[i] = exp_valid && w_exp_ready && (exp_chan == CW'(i));
      w_pop[i]  = act_valid && !w_empty[i] && (act_chan == CW'(i));
    end
  end

  assign exp_ready   = w_exp_ready;
  assign w_match     = (((w_act_head ^ act_data) & cmp_mask) == '0);
  assign w_all_empty = &w_empty;
  assign w_wd_fire   = !act_valid && !w_all_empty && (r_state != DONE) &&
                       (r_wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      r_res_pass  <= 1'b0;
      r_res_mis   <= 1'b0;
      r_res_unexp <= 1'b0;
    end else begin
      r_res_pass  <= w_act_hit && w_match;
      r_res_mis   <= w_act_hit && !w_match;
      r_res_unexp <= act_valid && !w_act_hit;
    end
  end

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      r_pass_cnt <= '0;
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
      r_err_kind <= ERR_NONE;
      r_timeout  <= 1'b0;
    end else begin
      if (r_res_pass) r_pass_cnt <= sat_inc(r_pass_cnt);
      if (r_res_mis || r_res_unexp) begin
        r_err_cnt  <= sat_inc(r_err_cnt);
        r_err_flag <= 1'b1;
        r_err_kind <= r_res_mis ? ERR_MISMATCH : ERR_UNEXPECTED;
      end
      if (w_wd_fire) begin
        r_timeout  <= 1'b1;
        r_err_flag <= 1'b1;
        r_err_kind <= ERR_TIMEOUT;
      end
    end
  end

  // Watchdog holds at its terminal value once reached; the state machine leaves RUN/DRAIN on fire.
  always_ff @(posedge tb_clk) begin
    if (tb_rst)                              r_wd <= '0;
    else if (act_valid || w_all_empty)       r_wd <= '0;
    else if (r_wd != WDW'(TIMEOUT - 1))      r_wd <= r_wd + WDW'(1);
  end

  always_ff @(posedge tb_clk) begin
    if (tb_rst) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (eot) w_state_nxt = DRAIN;
      DRAIN:   if (w_all_empty) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
    if (w_wd_fire) w_state_nxt = DONE;
  end

  assign pass_cnt = r_pass_cnt;
  assign err_cnt  = r_err_cnt;
  assign err_flag = r_err_flag;
  assign err_kind = r_err_kind;
  assign timeout  = r_timeout;
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_tb_scoreboard.sv
// Bench for tb_scoreboard: directed scenarios plus random traffic against a queue-based reference model.
module tb_tb_scoreboard;

  localparam int W       = 32;
  localparam int NCH     = 4;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 20;
  localparam int CW      = 2;

  localparam int PH_RUN   = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_DONE  = 2;

  localparam int R_NONE  = 0;
  localparam int R_PASS  = 1;
  localparam int R_MIS   = 2;
  localparam int R_UNEXP = 3;

  logic          tb_clk = 1'b0;
  logic          tb_rst;
  logic          exp_valid;
  logic          exp_ready;
  logic [CW-1:0] exp_chan;
  logic [W-1:0]  exp_data;
  logic          act_valid;
  logic [CW-1:0] act_chan;
  logic [W-1:0]  act_data;
  logic [W-1:0]  cmp_mask;
  logic          eot;
  logic [31:0]   pass_cnt;
  logic [31:0]   err_cnt;
  logic          err_flag;
  logic [1:0]    err_kind;
  logic          timeout;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected values per channel, counters, flags and test phase.
  logic [W-1:0] m_q [NCH][$];
  int unsigned  m_pass;
  int unsigned  m_err;
  int           m_kind;
  bit           m_flag;
  bit           m_to;
  int           m_phase;
  int           m_res;
  int           m_stall;

  tb_scoreboard #(
    .W(W), .NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .tb_clk    (tb_clk),
    .tb_rst    (tb_rst),
    .exp_valid (exp_valid),
    .exp_ready (exp_ready),
    .exp_chan  (exp_chan),
    .exp_data  (exp_data),
    .act_valid (act_valid),
    .act_chan  (act_chan),
    .act_data  (act_data),
    .cmp_mask  (cmp_mask),
    .eot       (eot),
    .pass_cnt  (pass_cnt),
    .err_cnt   (err_cnt),
    .err_flag  (err_flag),
    .err_kind  (err_kind),
    .timeout   (timeout),
    .done      (done)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    exp_valid = 1'b0;
    exp_chan  = '0;
    exp_data  = '0;
    act_valid = 1'b0;
    act_chan  = '0;
    act_data  = '0;
    cmp_mask  = '1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_q[c].delete();
    m_pass  = 0;
    m_err   = 0;
    m_kind  = 0;
    m_flag  = 0;
    m_to    = 0;
    m_phase = PH_RUN;
    m_res   = R_NONE;
    m_stall = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    eot    = 1'b0;
    tb_rst = 1'b1;
    repeat (2) @(posedge tb_clk);
    #1;
    tb_rst = 1'b0;
    model_reset();
    check("rst pass_cnt", pass_cnt, 0);
    check("rst err_cnt", err_cnt, 0);
    check("rst err_flag", err_flag, 0);
    check("rst err_kind", err_kind, 0);
    check("rst timeout", timeout, 0);
    check("rst done", done, 0);
  endtask

  // One clock cycle: predict from the current inputs, advance, compare all outputs.
  task automatic step();
    bit           rdy;
    bit           all_empty;
    int           res;
    logic [W-1:0] head;
    #1;
    all_empty = 1;
    for (int c = 0; c < NCH; c++) if (m_q[c].size() != 0) all_empty = 0;
    rdy = (int'(exp_chan) < NCH) && (m_phase != PH_DONE) && (m_q[exp_chan].size() < DEPTH);
    check("exp_ready", exp_ready, rdy);

    res = R_NONE;
    if (act_valid) begin
      if (int'(act_chan) < NCH && m_q[act_chan].size() > 0) begin
        head = m_q[act_chan].pop_front();
        res  = (((head ^ act_data) & cmp_mask) == '0) ? R_PASS : R_MIS;
      end else begin
        res = R_UNEXP;
      end
    end
    if (exp_valid && rdy) m_q[exp_chan].push_back(exp_data);

    // The previous cycle's compare outcome becomes visible at this edge.
    case (m_res)
      R_PASS:  if (m_pass != 32'hFFFF_FFFF) m_pass++;
      R_MIS:   begin if (m_err != 32'hFFFF_FFFF) m_err++; m_kind = 1; m_flag = 1; end
      R_UNEXP: begin if (m_err != 32'hFFFF_FFFF) m_err++; m_kind = 2; m_flag = 1; end
      default: ;
    endcase
    m_res = res;

    if (act_valid || all_empty) m_stall = 0;
    else                        m_stall++;

    if (m_stall >= TIMEOUT && m_phase != PH_DONE) begin
      m_to = 1; m_flag = 1; m_kind = 3; m_phase = PH_DONE;
    end else if (m_phase == PH_RUN && eot) begin
      m_phase = PH_DRAIN;
    end else if (m_phase == PH_DRAIN && all_empty) begin
      m_phase = PH_DONE;
    end

    @(posedge tb_clk);
    #1;
    check("pass_cnt", pass_cnt, m_pass);
    check("err_cnt", err_cnt, m_err);
    check("err_kind", err_kind, m_kind);
    check("err_flag", err_flag, m_flag);
    check("timeout", timeout, m_to);
    check("done", done, m_phase == PH_DONE);
  endtask

  task automatic push(input int ch, input logic [W-1:0] d);
    clear_inputs();
    exp_valid = 1'b1; exp_chan = CW'(ch); exp_data = d;
    step();
    clear_inputs();
  endtask

  task automatic act(input int ch, input logic [W-1:0] d, input logic [W-1:0] m);
    clear_inputs();
    act_valid = 1'b1; act_chan = CW'(ch); act_data = d; cmp_mask = m;
    step();
    clear_inputs();
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    tb_rst = 1'b1;
    clear_inputs();
    eot = 1'b0;
    do_reset();

    // Basic pass with full mask
    push(0, 32'hA5A5_0001);
    act(0, 32'hA5A5_0001, 32'hFFFF_FFFF);
    idle(1);
    check("basic pass_cnt", pass_cnt, 1);
    check("basic err_cnt", err_cnt, 0);

    // Masked compare: low byte ignored passes, full mask mismatches
    push(2, 32'h0000_00F0);
    act(2, 32'h0000_00FF, 32'hFFFF_FF00);
    push(2, 32'h0000_00F0);
    act(2, 32'h0000_00FF, 32'hFFFF_FFFF);
    idle(1);
    check("mask pass_cnt", pass_cnt, 2);
    check("mask err_cnt", err_cnt, 1);
    check("mask err_kind", err_kind, 1);
    check("mask err_flag", err_flag, 1);

    // Fill ch1, refuse the 9th, ch3 still open, drain in order; twice for pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) push(1, 32'(r * 100 + i));
      clear_inputs();
      exp_chan = CW'(1);
      #1;
      check("ch1 full ready", exp_ready, 0);
      push(1, 32'hDEAD_BEEF);
      clear_inputs();
      exp_chan = CW'(3);
      #1;
      check("ch3 ready", exp_ready, 1);
      for (int i = 0; i < DEPTH; i++) act(1, 32'(r * 100 + i), 32'hFFFF_FFFF);
      idle(1);
    end
    check("fill pass_cnt", pass_cnt, 2 + 2 * DEPTH);
    check("fill err_cnt", err_cnt, 1);

    // Unexpected on empty ch3; same-cycle push+act on empty ch0 leaves the entry queued
    act(3, 32'h1234, 32'hFFFF_FFFF);
    idle(1);
    check("unexp err_cnt", err_cnt, 2);
    check("unexp err_kind", err_kind, 2);
    clear_inputs();
    exp_valid = 1'b1; exp_chan = CW'(0); exp_data = 32'h0000_0077;
    act_valid = 1'b1; act_chan = CW'(0); act_data = 32'h0000_0077;
    step();
    act(0, 32'h0000_0077, 32'hFFFF_FFFF);
    idle(1);
    check("pushpop err_cnt", err_cnt, 3);
    check("pushpop pass_cnt", pass_cnt, 3 + 2 * DEPTH);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int ch;
      clear_inputs();
      exp_valid = ($urandom_range(0, 99) < 45);
      exp_chan  = CW'($urandom_range(0, NCH - 1));
      exp_data  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      act_valid = ($urandom_range(0, 99) < 55);
      ch        = $urandom_range(0, NCH - 1);
      act_chan  = CW'(ch);
      if (m_q[ch].size() > 0 && $urandom_range(0, 3) != 0) act_data = m_q[ch][0];
      else                                                act_data = $urandom;
      cmp_mask  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      step();
    end
    clear_inputs();

    // Watchdog: one pending entry, no activity
    do_reset();
    push(0, 32'h5555_AAAA);
    idle(TIMEOUT - 1);
    check("pre-timeout", timeout, 0);
    idle(1);
    check("timeout", timeout, 1);
    check("timeout err_kind", err_kind, 3);
    check("timeout done", done, 1);
    check("timeout err_cnt", err_cnt, 0);
    check("timeout err_flag", err_flag, 1);
    act(0, 32'h5555_AAAA, 32'hFFFF_FFFF);
    idle(1);
    check("done still compares", pass_cnt, 1);

    // End of test with pending work, then reset out of DONE
    do_reset();
    push(0, 32'h0000_0001);
    push(0, 32'h0000_0002);
    eot = 1'b1;
    idle(1);
    act(0, 32'h0000_0001, 32'hFFFF_FFFF);
    act(0, 32'h0000_0002, 32'hFFFF_FFFF);
    check("drain not done", done, 0);
    idle(1);
    check("drain done", done, 1);
    push(2, 32'h0000_0003);
    idle(2);
    check("eot pass_cnt", pass_cnt, 2);
    do_reset();

    // End of test with all queues already empty: done two edges later
    eot = 1'b1;
    idle(1);
    check("eot empty 1", done, 0);
    idle(1);
    check("eot empty 2", done, 1);
    eot = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
